// File: rtl/hpm_pkg.sv
// Shared constants for the hardware performance-monitor unit: CSR addresses,
// counter slot indices, the event-select enumeration and the helper that says
// which counter slots exist for a given number of programmable counters.
package hpm_pkg;

  // CSR addresses (machine-mode counter block)
  localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH        = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET       = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH      = 12'hB82;
  localparam logic [11:0] CSR_MHPMCNT_BASE   = 12'hB00;
  localparam logic [11:0] CSR_MHPMCNTH_BASE  = 12'hB80;
  localparam logic [11:0] CSR_MHPMEVENT_BASE = 12'h320;
  localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
  localparam logic [11:0] CSR_MHPMOVF        = 12'h7C0;

  // Counter slot indices; slot 1 (time) is an unmapped address slot
  localparam int IDX_CYCLE    = 0;
  localparam int IDX_TIME     = 1;
  localparam int IDX_INSTRET  = 2;
  localparam int IDX_HPM_BASE = 3;

  // Event-select values written into mhpmeventN; value k counts event_i[k-1]
  typedef enum logic [3:0] {
    EV_NONE     = 4'd0,
    EV_LOAD     = 4'd1,
    EV_STORE    = 4'd2,
    EV_BRANCH   = 4'd3,
    EV_BR_TAKEN = 4'd4,
    EV_STALL    = 4'd5,
    EV_FLUSH    = 4'd6,
    EV_JUMP     = 4'd7,
    EV_MUL      = 4'd8
  } hpm_event_e;

  // Bit i set when counter slot i exists (cycle, instret and the HPM slots)
  function automatic logic [31:0] impl_mask(input int num_hpm);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i != IDX_TIME && i <= num_hpm + 2) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One performance-counter slice: CNT_WIDTH-bit up counter with an inhibit,
// separate lo/hi CSR write ports and a wrap pulse. A CSR write in the same
// cycle as an increment takes priority and the increment is dropped.
module hpm_counter
  import hpm_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 inhibit,
  input  logic                 we_lo,
  input  logic                 we_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wrap
);

  localparam int HI_W = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] count_reg;
  logic                 step;

  // An increment only happens when enabled, not frozen and not overwritten
  assign step  = inc && !inhibit && !we_lo && !we_hi;
  assign wrap  = step && (&count_reg);
  assign count = count_reg;

  // Counter register: writes replace their half, otherwise count up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) count_reg[31:0] <= wdata;
      if (we_hi) count_reg[CNT_WIDTH-1:32] <= wdata[HI_W-1:0];
    end else if (step) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/hpm_counter_unit.sv
// CSR-visible performance-monitor block: mcycle, minstret and NUM_HPM
// programmable event counters with inhibit, event select and sticky overflow.
// Optional feature macro: HPM_OVF_IRQ_EN -- when defined, ovf_irq is a
// registered OR of the overflow flags; otherwise ovf_irq is tied low.
module hpm_counter_unit
  import hpm_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instret_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  csr_we,
  input  logic                  csr_re,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_rvalid,
  output logic                  csr_err,
  output logic                  ovf_irq
);

  localparam int          NUM_CNT = NUM_HPM + 3;
  localparam int          EW      = $clog2(NUM_EVENTS + 1);
  localparam logic [31:0] IMPL    = impl_mask(NUM_HPM);

  logic [CNT_WIDTH-1:0] count [NUM_CNT];
  logic [EW-1:0]        sel_reg [NUM_CNT];
  logic [NUM_CNT-1:0]   inc, wrap, lo_hit, hi_hit, evt_hit, we_lo, we_hi;
  logic [31:0]          inhibit_reg, ovf_reg, wrap_vec, ovf_clr, rd_data;
  logic                 inh_hit, ovf_hit, mapped;

  // Increment enables: cycle always, instret on retire, HPM on selected event
  always_comb begin
    inc = '0;
    inc[IDX_CYCLE]   = 1'b1;
    inc[IDX_INSTRET] = instret_i;
    for (int i = IDX_HPM_BASE; i < NUM_CNT; i++) begin
      for (int k = 1; k <= NUM_EVENTS; k++) begin
        if (sel_reg[i] == EW'(k) && event_i[k-1]) inc[i] = 1'b1;
      end
    end
  end

  // Address decode and read-data mux, all from pre-write state
  always_comb begin
    lo_hit  = '0;
    hi_hit  = '0;
    evt_hit = '0;
    inh_hit = 1'b0;
    ovf_hit = 1'b0;
    mapped  = 1'b0;
    rd_data = '0;
    if (csr_addr == CSR_MCOUNTINHIBIT) begin
      inh_hit = 1'b1;
      mapped  = 1'b1;
      rd_data = inhibit_reg;
    end
    if (csr_addr == CSR_MHPMOVF) begin
      ovf_hit = 1'b1;
      mapped  = 1'b1;
      rd_data = ovf_reg;
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (i != IDX_TIME) begin
        if (csr_addr == 12'(CSR_MHPMCNT_BASE + 12'(i))) begin
          lo_hit[i] = 1'b1;
          mapped    = 1'b1;
          rd_data   = count[i][31:0];
        end
        if (csr_addr == 12'(CSR_MHPMCNTH_BASE + 12'(i))) begin
          hi_hit[i] = 1'b1;
          mapped    = 1'b1;
          rd_data   = 32'(count[i][CNT_WIDTH-1:32]);
        end
        if (i >= IDX_HPM_BASE && csr_addr == 12'(CSR_MHPMEVENT_BASE + 12'(i))) begin
          evt_hit[i] = 1'b1;
          mapped     = 1'b1;
          rd_data    = 32'(sel_reg[i]);
        end
      end
    end
  end

  assign we_lo   = lo_hit & {NUM_CNT{csr_we}};
  assign we_hi   = hi_hit & {NUM_CNT{csr_we}};
  assign ovf_clr = (csr_we && ovf_hit) ? csr_wdata : 32'h0;

  // Widen the per-slot wrap pulses to the 32-bit CSR layout
  always_comb begin
    wrap_vec = '0;
    for (int i = 0; i < NUM_CNT; i++) wrap_vec[i] = wrap[i];
  end

  // One counter slice per implemented slot; the time slot reads as zero
  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    if (gi == IDX_TIME) begin : g_time
      logic unused_time;
      assign count[gi]   = '0;
      assign wrap[gi]    = 1'b0;
      assign unused_time = ^{inc[gi], we_lo[gi], we_hi[gi]};
    end else begin : g_impl
      hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc[gi]),
        .inhibit (inhibit_reg[gi]),
        .we_lo   (we_lo[gi]),
        .we_hi   (we_hi[gi]),
        .wdata   (csr_wdata),
        .count   (count[gi]),
        .wrap    (wrap[gi])
      );
    end
  end

  // Inhibit mask; unimplemented bits are forced to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inhibit_reg <= '0;
    else if (csr_we && inh_hit) inhibit_reg <= csr_wdata & IMPL;
  end

  // Sticky overflow: write-1-to-clear, a same-cycle wrap wins over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_reg <= '0;
    else ovf_reg <= ((ovf_reg & ~ovf_clr) | wrap_vec) & IMPL;
  end

  // Event selects; only the low EW bits are stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) sel_reg[i] <= '0;
    end else if (csr_we) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (evt_hit[i]) sel_reg[i] <= csr_wdata[EW-1:0];
      end
    end
  end

  // Registered read response and unmapped-access error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
      csr_err    <= 1'b0;
    end else begin
      csr_rvalid <= csr_re;
      csr_err    <= (csr_re || csr_we) && !mapped;
      if (csr_re) csr_rdata <= rd_data;
    end
  end

`ifdef HPM_OVF_IRQ_EN
  // Interrupt follows the OR of the overflow flags one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_irq <= 1'b0;
    else ovf_irq <= |ovf_reg;
  end
`else
  assign ovf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_counter_unit.sv
// Scoreboard bench for hpm_counter_unit: the driver updates a behavioural
// model of the counter block and queues expected read/error responses; a
// monitor on the falling edge pops and compares whatever the DUT presents.
module tb_hpm_counter_unit;

  localparam int NH = 4;
  localparam int NE = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instret_i = 1'b0;
  logic [NE-1:0] event_i = '0;
  logic          csr_we = 1'b0;
  logic          csr_re = 1'b0;
  logic [11:0]   csr_addr = '0;
  logic [31:0]   csr_wdata = '0;
  logic [31:0]   csr_rdata;
  logic          csr_rvalid, csr_err, ovf_irq;

  hpm_counter_unit #(.NUM_HPM(NH), .NUM_EVENTS(NE), .CNT_WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .instret_i  (instret_i),
    .event_i    (event_i),
    .csr_we     (csr_we),
    .csr_re     (csr_re),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_rvalid (csr_rvalid),
    .csr_err    (csr_err),
    .ovf_irq    (ovf_irq)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endfunction

  // ---------------- behavioural model ----------------
  logic [63:0] cnt_m [32];
  logic [3:0]  sel_m [32];
  logic [31:0] inh_m, ovf_m, impl_m;
  logic        irq_m;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      cnt_m[i] = '0;
      sel_m[i] = '0;
    end
    inh_m = '0;
    ovf_m = '0;
    irq_m = 1'b0;
  endfunction

  // Returns {mapped, data} for a CSR read of the current model state
  function automatic logic [32:0] mread(logic [11:0] a);
    if (a == 12'h320) return {1'b1, inh_m};
    if (a == 12'h7C0) return {1'b1, ovf_m};
    for (int i = 0; i <= NH + 2; i++) begin
      if (i != 1) begin
        if (a == 12'(12'hB00 + i)) return {1'b1, cnt_m[i][31:0]};
        if (a == 12'(12'hB80 + i)) return {1'b1, cnt_m[i][63:32]};
        if (i >= 3 && a == 12'(12'h320 + i)) return {1'b1, 28'h0, sel_m[i]};
      end
    end
    return 33'h0;
  endfunction

  // Advance the model by one clock edge with the given inputs
  function automatic void model_step(logic ins, logic [NE-1:0] ev, logic we,
                                     logic [11:0] a, logic [31:0] wd);
    logic [31:0] wraps;
    logic        bump;
    wraps = '0;
    for (int i = 0; i <= NH + 2; i++) begin
      if (i != 1) begin
        if (i == 0) bump = 1'b1;
        else if (i == 2) bump = ins;
        else bump = (sel_m[i] >= 4'd1 && int'(sel_m[i]) <= NE) ? ev[int'(sel_m[i]) - 1] : 1'b0;
        if (inh_m[i]) bump = 1'b0;
        if (we && a == 12'(12'hB00 + i)) cnt_m[i][31:0] = wd;
        else if (we && a == 12'(12'hB80 + i)) cnt_m[i][63:32] = wd;
        else if (bump) begin
          if (cnt_m[i] == 64'hFFFF_FFFF_FFFF_FFFF) wraps[i] = 1'b1;
          cnt_m[i] = cnt_m[i] + 64'd1;
        end
      end
    end
    irq_m = |ovf_m;
    if (we && a == 12'h320) inh_m = wd & impl_m;
    if (we && a == 12'h7C0) ovf_m = ovf_m & ~wd;
    ovf_m = ovf_m | wraps;
    for (int i = 3; i <= NH + 2; i++) begin
      if (we && a == 12'(12'h320 + i)) sel_m[i] = wd[3:0];
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [11:0] a;
    logic        v;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t exp_q[$];

  // Drive one cycle, queue the expected response, advance the model
  task automatic tick(logic ins, logic [NE-1:0] ev, logic we, logic re,
                      logic [11:0] a, logic [31:0] wd);
    logic [32:0] r;
    exp_t        e;
    instret_i = ins;
    event_i   = ev;
    csr_we    = we;
    csr_re    = re;
    csr_addr  = a;
    csr_wdata = wd;
    r = mread(a);
    if (re || (we && !r[32])) begin
      e.a = a;
      e.v = re;
      e.d = re ? r[31:0] : 32'h0;
      e.e = !r[32];
      exp_q.push_back(e);
    end
    model_step(ins, ev, we, a, wd);
    @(posedge clk);
    #1;
`ifdef HPM_OVF_IRQ_EN
    chk("ovf_irq", {63'h0, ovf_irq}, {63'h0, irq_m});
`else
    chk("ovf_irq_tied", {63'h0, ovf_irq}, 64'h0);
`endif
  endtask

  task automatic rd(logic [11:0] a);
    tick(1'b0, '0, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic wr(logic [11:0] a, logic [31:0] d);
    tick(1'b0, '0, 1'b1, 1'b0, a, d);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  // Monitor: compare every presented response against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (csr_rvalid || csr_err)) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", {62'h0, csr_rvalid, csr_err}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rvalid@%03h", e.a), {63'h0, csr_rvalid}, {63'h0, e.v});
          chk($sformatf("err@%03h", e.a), {63'h0, csr_err}, {63'h0, e.e});
          if (e.v) chk($sformatf("rdata@%03h", e.a), {32'h0, csr_rdata}, {32'h0, e.d});
        end
      end
    end
  end

  logic [11:0] addr_tab [24] = '{
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
    12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'h323, 12'h324, 12'h325, 12'h326,
    12'h320, 12'h7C0, 12'hB01, 12'hB81, 12'hB07, 12'h327, 12'h321, 12'h7C1
  };

  logic [11:0] ra;
  logic [31:0] rdv;
  int          op;

  initial begin
    impl_m = '0;
    for (int i = 0; i < 32; i++) if (i != 1 && i <= NH + 2) impl_m[i] = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", {32'h0, csr_rdata}, 64'h0);
    chk("reset_rvalid", {63'h0, csr_rvalid}, 64'h0);
    chk("reset_err", {63'h0, csr_err}, 64'h0);
    chk("reset_irq", {63'h0, ovf_irq}, 64'h0);
    rst = 1'b0;

    // 100 idle cycles then read cycle/instret
    idle(100);
    rd(12'hB00);
    rd(12'hB80);
    rd(12'hB02);

    // Event 1 on counter 3, inhibited after four pulses
    wr(12'h323, 32'h1);
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h01, 1'b0, 1'b0, 12'h0, 32'h0);
    wr(12'h320, 32'h8);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h01, 1'b0, 1'b0, 12'h0, 32'h0);
    rd(12'hB03);
    rd(12'hB04);
    rd(12'hB02);
    wr(12'h320, 32'h0);

    // mcycle wrap, sticky overflow, write-1-to-clear
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'hFFFF_FFFF);
    idle(3);
    rd(12'h7C0);
    rd(12'hB80);
    wr(12'h7C0, 32'h1);
    idle(1);
    rd(12'h7C0);

    // Write and increment on minstret in the same cycle
    tick(1'b1, '0, 1'b1, 1'b0, 12'hB02, 32'h10);
    rd(12'hB02);

    // Unmapped accesses and an out-of-range event select
    rd(12'hB01);
    wr(12'hB01, 32'h1234);
    wr(12'h324, 32'hF);
    for (int i = 0; i < 10; i++) tick(1'b0, 8'hFF, 1'b0, 1'b0, 12'h0, 32'h0);
    rd(12'hB04);
    rd(12'h324);
    // Read and write of the same address in one cycle return the old value
    tick(1'b0, '0, 1'b1, 1'b1, 12'hB03, 32'hABCD);
    rd(12'hB03);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      op = $urandom_range(0, 9);
      ra = addr_tab[$urandom_range(0, 23)];
      rdv = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      if (ra == 12'h320 || ra == 12'h7C0) rdv = $urandom & $urandom;
      if (ra >= 12'h321 && ra <= 12'h327) rdv = $urandom_range(0, 15);
      tick(1'(op % 2), NE'($urandom), op == 0, op >= 6, ra, rdv);
    end

    // Force a wrap, then reset asynchronously with a read in flight
    wr(12'h320, 32'h0);
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFE);
    idle(4);
    rd(12'hB00);
    rst = 1'b1;
    #2;
    chk("async_rst_rvalid", {63'h0, csr_rvalid}, 64'h0);
    chk("async_rst_rdata", {32'h0, csr_rdata}, 64'h0);
    chk("async_rst_irq", {63'h0, ovf_irq}, 64'h0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    rd(12'hB00);
    rd(12'h7C0);
    rd(12'hB02);
    rd(12'h323);

    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hpm_counter_unit.md
# hpm_counter_unit

Parametrised hardware performance-monitor unit for the core, generalising the fixed cycle/instret counters into a CSR-visible block. It holds `mcycle`, `minstret` and `NUM_HPM` programmable event counters, each `CNT_WIDTH` wide, plus per-counter inhibit, event select and sticky overflow. It sits beside the CSR file in the top level, fed by retire and microarchitectural event strobes. Benches read it to compute CPI and event rates without hierarchical peeking.

## Interface
- `NUM_HPM`, 4: programmable counters, 1..29, at `mhpmcounter3..`
- `NUM_EVENTS`, 8: width of `event_i`
- `CNT_WIDTH`, 64: counter width, 33..64; reads zero-extend to 64
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `instret_i`  in  1  one pulse per retired instruction (the register-file `w_en`/retire strobe)
- `event_i`  in  `NUM_EVENTS`  event strobes, one increment per cycle high
- `csr_we`  in  1  CSR write strobe
- `csr_re`  in  1  CSR read strobe
- `csr_addr`  in  12  CSR address
- `csr_wdata`  in  32  write data
- `csr_rdata`  out  32  registered read data
- `csr_rvalid`  out  1  read data valid, one cycle after `csr_re`
- `csr_err`  out  1  one-cycle pulse for an unmapped address on `csr_re`/`csr_we`
- `ovf_irq`  out  1  overflow interrupt (only with `HPM_OVF_IRQ_EN`)

## Operation
- Address map: `mcycle` 0xB00/0xB80 (lo/hi), `minstret` 0xB02/0xB82, `mhpmcounterN` 0xB00+N / 0xB80+N, `mhpmeventN` 0x320+N, `mcountinhibit` 0x320, overflow status `mhpmovf` 0x7C0.
- Counter index 0 = cycle, 2 = instret, 3..2+NUM_HPM = HPM. Index 1 (time) is unmapped.
- Increment per cycle when not inhibited: cycle +1 always; instret +1 on `instret_i`; HPM N +1 when `mhpmeventN` = k, 1 ≤ k ≤ NUM_EVENTS, and `event_i[k-1]`=1. Select 0 or > NUM_EVENTS counts nothing.
- `mcountinhibit[i]`=1 freezes counter i. Unimplemented bits read 0.
- Lo writes replace bits [31:0]. Hi writes replace bits [CNT_WIDTH-1:32]; excess wdata is dropped.
- A write in the same cycle as an increment wins; that increment is lost.
- Wrap: all-ones to 0 sets sticky `mhpmovf[i]`. Writing 1 to a `mhpmovf` bit clears it. If a wrap and a clear land on the same bit, the set wins.
- A read and a write to the same address in one cycle return the pre-write value.
- `mhpmevent` fields are `$clog2(NUM_EVENTS+1)` bits; upper bits read 0.

## Timing
- Reset: all counters, selects, inhibit and ovf = 0; `csr_rdata`=0, `csr_rvalid`=0, `csr_err`=0, `ovf_irq`=0. A reset mid-count zeroes state immediately, asynchronously.
- Counter updates and CSR writes take effect at the next `clk` edge.
- Read latency is 1 cycle. `csr_rdata` holds its value until the next read. Back-to-back reads are allowed every cycle.
- `csr_err` is asserted in the cycle after the offending access. Writes to unmapped addresses have no effect.
- Hi/lo reads are not atomic. Software reads hi, lo, hi again.

## Configuration
- `HPM_OVF_IRQ_EN` defined: `ovf_irq` is registered and equals OR(`mhpmovf`), so it rises 1 cycle after the wrapping edge and falls 1 cycle after the clear.
- `HPM_OVF_IRQ_EN` undefined: `ovf_irq` is tied to 0. `mhpmovf` stays readable and sticky.

## Structure
- `hpm_pkg`: CSR address constants, counter index constants, event enumeration (`EV_NONE`, `EV_LOAD`, `EV_STORE`, `EV_BRANCH`, `EV_BR_TAKEN`, `EV_STALL`, `EV_FLUSH`, `EV_JUMP`, `EV_MUL`).
- Sub-module `hpm_counter`: one counter slice with increment enable, inhibit, lo/hi write ports and a wrap pulse output. Instantiated NUM_HPM+2 times via generate.

## Test plan
- Reset released, 100 cycles idle → `mcycle`=100±1, `minstret`=0, `csr_rvalid` one cycle after every read.
- `mhpmevent3`=1, pulse `event_i[0]` 7 times, `mcountinhibit`=0x8 mid-stream after 4 → `mhpmcounter3`=4; unrelated counters unaffected.
- Write `mcycle` lo=0xFFFFFFFE, hi=0xFFFFFFFF, run 3 cycles → wraps to small value, `mhpmovf[0]`=1; `ovf_irq`=1 with macro, 0 without; write 1 to clear → 0.
- Write and increment on `minstret` in the same cycle with wdata 0x10 → reads 0x10.
- Read 0xB01 → `csr_err` pulse, `csr_rdata`=0. Set `mhpmevent4`=15 with NUM_EVENTS=8 → never counts.
- Assert `rst` asynchronously mid-sort run → all counters and `ovf_irq` 0 before the next edge.
